irq_encoder8: RTL and testbench
===============================

Name: irq_encoder8

Overview:
- 8-input request encoder: the binary-output counterpart of the 3-to-8 one-hot decoders already in the library.
- Latches request lines into a pending register and applies a mask.
- Selects one unmasked pending request by fixed priority and presents its 3-bit index to the CPU control path.
- Presentation uses a valid/ack handshake; the serviced bit is cleared only on ack.

Parameters:
EDGE, 8'h00, per-bit trigger mode: 1 = rising-edge capture, 0 = level capture.
HIGH_FIRST, 0, priority direction: 0 = index 0 highest priority, 1 = index 7 highest priority.

Ports:
clk  input  1  system clock; all state updates on posedge.
reset_n  input  1  asynchronous active-low reset.
req  input  8  request lines, synchronous to clk.
mask_we  input  1  write-enable for the mask register.
mask_din  input  8  new mask value; 1 = bit enabled.
ack  input  1  consumer has taken the presented vector.
valid  output  1  vector holds a presented request.
vector  output  3  index of the presented request.
pending  output  8  raw pending register, for status reads.
mask  output  8  current mask register.

Behaviour:
- Reset (reset_n low, asynchronous; no clock needed): pending=0, mask=0, valid=0, vector=0, req history register=0, FSM=IDLE.
- Capture, per bit i:
  - Level bits (EDGE[i]=0): set pending[i] on any clock where req[i]=1.
  - Edge bits (EDGE[i]=1): set pending[i] when req[i]=1 and the previous-cycle sample was 0.
  - The history register updates every cycle.
- Clear: pending[vector] clears on the clock where valid && ack.
  - Set and clear of the same bit in the same cycle: set wins, so the bit stays pending.
  - Level bits whose req is still high re-pend immediately.
- Mask: mask_we loads mask_din on the clock edge. Masking never clears pending; it only hides bits from selection.
- Selection: candidates = pending & mask. The priority pick is the lowest set index (HIGH_FIRST=0) or the highest set index (HIGH_FIRST=1).
- FSM, 2 states:
  - IDLE: valid=0. If candidates != 0, load vector with the pick, set valid=1 and go to PRESENT.
    - Latency: a req asserted at edge N sets pending at N; valid and vector appear at edge N+1.
  - PRESENT: valid=1. vector is held stable; no preemption by higher-priority arrivals.
    - On ack: clear the bit and return to IDLE (valid=0 next cycle).
    - Minimum gap between back-to-back presentations is one IDLE cycle.
- Mask change while PRESENT: the presented vector stays valid until ack, even if its bit is now masked.
- ack while IDLE: ignored; no state change.
- reset_n asserted mid-handshake: everything returns to reset values immediately. After reset deassertion, requests still high are re-captured normally. For edge bits, the history is 0 after reset, so a req held high across reset counts as a new edge.
- vector is 3 bits, with no encoding overflow. When valid=0, vector retains its last value; consumers must qualify vector with valid.

Test Plan:
1. Reset, mask=8'hFF, EDGE=0, pulse req=8'h08 for 1 cycle -> pending=8'h08, next cycle valid=1 and vector=3; ack -> pending=0, valid=0.
2. HIGH_FIRST=0, req=8'h90 simultaneously held for 1 cycle -> vector=4 presented first; after ack, one IDLE cycle, then vector=7.
3. HIGH_FIRST=1, same stimulus -> vector=7 first, then vector=4.
4. While PRESENT with vector=5, raise req[0] -> vector stays 5 until ack; then vector=0.
5. mask=8'hFE, req[0] held -> pending[0]=1, valid stays 0. Write mask=8'hFF -> valid=1, vector=0 one cycle later.
6. EDGE=8'h01, req[0] held high for 10 cycles -> exactly one presentation. Same-cycle new edge plus ack on bit 0 -> pending[0] remains 1. reset_n low mid-PRESENT -> valid=0 and pending=0 with no clock edge.

Source files
------------

// File: rtl/irq_encoder8.sv
// 8-input interrupt request encoder: pending capture, masking, fixed-priority
// selection and a valid/ack handshake presenting the chosen 3-bit index.
module irq_encoder8 #(
  parameter logic [7:0] EDGE       = 8'h00,
  parameter bit         HIGH_FIRST = 1'b0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] req,
  input  logic       mask_we,
  input  logic [7:0] mask_din,
  input  logic       ack,
  output logic       valid,
  output logic [2:0] vector,
  output logic [7:0] pending,
  output logic [7:0] mask
);

  localparam int unsigned N  = 8;
  localparam int unsigned IW = 3;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [N-1:0]  req_q;
  logic [N-1:0]  set_c;
  logic [N-1:0]  clr_c;
  logic [N-1:0]  cand_c;
  logic [IW-1:0] pick_c;
  logic          load_c;

  // Edge bits only set on a 0->1 transition of the sampled request.
  assign set_c  = req & ~(EDGE & req_q);
  assign cand_c = pending & mask;
  assign valid  = (state == PRESENT);

  // Fixed-priority pick; the last hit in scan order wins.
  always_comb begin
    pick_c = '0;
    if (HIGH_FIRST) begin
      for (int i = 0; i < int'(N); i++) begin
        if (cand_c[i]) pick_c = IW'(i);
      end
    end else begin
      for (int i = int'(N) - 1; i >= 0; i--) begin
        if (cand_c[i]) pick_c = IW'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cand_c != '0) state_nxt = PRESENT;
      PRESENT: if (ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    load_c = 1'b0;
    clr_c  = '0;
    case (state)
      IDLE:    load_c = (cand_c != '0);
      PRESENT: if (ack) clr_c = N'(1) << vector;
      default: ;
    endcase
  end

  // Set has priority over clear so a re-asserting request is never lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vector  <= '0;
      pending <= '0;
      mask    <= '0;
      req_q   <= '0;
    end else begin
      if (load_c) vector <= pick_c;
      pending <= (pending & ~clr_c) | set_c;
      if (mask_we) mask <= mask_din;
      req_q <= req;
    end
  end

endmodule

// File: tb/tb_irq_encoder8.sv
// Bench for irq_encoder8: three parameterisations driven by shared stimulus,
// checked every cycle against a behavioural model plus literal expectations.
module tb_irq_encoder8;

  typedef struct packed {
    logic [7:0] p;
    logic [7:0] m;
    logic [7:0] h;
    logic       v;
    logic [2:0] vec;
  } mstate_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  req = 8'h00;
  logic        mask_we = 1'b0;
  logic [7:0]  mask_din = 8'h00;
  logic        ack = 1'b0;
  logic [2:0]  dv;
  logic [8:0]  dvec;
  logic [23:0] dpend;
  logic [23:0] dmask;

  int checks = 0;
  int passes = 0;
  int pres = 0;
  mstate_t ms [3];

  always #5 clk = ~clk;

  irq_encoder8 #(.EDGE(8'h00), .HIGH_FIRST(1'b0)) dut0 (
    .clk(clk), .reset_n(reset_n), .req(req), .mask_we(mask_we), .mask_din(mask_din),
    .ack(ack), .valid(dv[0]), .vector(dvec[2:0]), .pending(dpend[7:0]), .mask(dmask[7:0]));
  irq_encoder8 #(.EDGE(8'h00), .HIGH_FIRST(1'b1)) dut1 (
    .clk(clk), .reset_n(reset_n), .req(req), .mask_we(mask_we), .mask_din(mask_din),
    .ack(ack), .valid(dv[1]), .vector(dvec[5:3]), .pending(dpend[15:8]), .mask(dmask[15:8]));
  irq_encoder8 #(.EDGE(8'h01), .HIGH_FIRST(1'b0)) dut2 (
    .clk(clk), .reset_n(reset_n), .req(req), .mask_we(mask_we), .mask_din(mask_din),
    .ack(ack), .valid(dv[2]), .vector(dvec[8:6]), .pending(dpend[23:16]), .mask(dmask[23:16]));

  function automatic logic [7:0] edg_of(int k);
    return (k == 2) ? 8'h01 : 8'h00;
  endfunction

  function automatic bit hf_of(int k);
    return (k == 1);
  endfunction

  // Lowest set bit via two's-complement isolation, highest via ceil-log2.
  function automatic logic [2:0] pick(logic [7:0] c, bit h);
    logic [8:0] x;
    if (h) begin
      x = {1'b0, c} + 9'd1;
      return 3'($clog2(x) - 1);
    end
    x = {1'b0, c & (~c + 8'd1)};
    return 3'($clog2(x));
  endfunction

  function automatic mstate_t step(mstate_t s, logic [7:0] em, bit h, logic [7:0] r,
                                   logic mwe, logic [7:0] md, logic a);
    mstate_t n = s;
    logic [7:0] cand = s.p & s.m;
    if (s.v && a) begin
      n.v = 1'b0;
      n.p[s.vec] = 1'b0;
    end else if (!s.v && cand != 8'h00) begin
      n.v = 1'b1;
      n.vec = pick(cand, h);
    end
    for (int i = 0; i < 8; i++) begin
      if (em[i] ? (r[i] && !s.h[i]) : r[i]) n.p[i] = 1'b1;
    end
    if (mwe) n.m = md;
    n.h = r;
    return n;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    for (int k = 0; k < 3; k++) begin
      if (!reset_n) ms[k] <= '0;
      else ms[k] <= step(ms[k], edg_of(k), hf_of(k), req, mask_we, mask_din, ack);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("dut%0d valid", k),   32'(dv[k]),          32'(ms[k].v));
        chk($sformatf("dut%0d vector", k),  32'(dvec[k*3 +: 3]), 32'(ms[k].vec));
        chk($sformatf("dut%0d pending", k), 32'(dpend[k*8 +: 8]), 32'(ms[k].p));
        chk($sformatf("dut%0d mask", k),    32'(dmask[k*8 +: 8]), 32'(ms[k].m));
      end
    end
  end

  task automatic nc(int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic drain();
    req = 8'h00;
    ack = 1'b1;
    nc(16);
    ack = 1'b0;
    nc();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    nc();
    chk("reset valid",   32'(dv),    32'h0);
    chk("reset pending", 32'(dpend), 32'h0);
    chk("reset mask",    32'(dmask), 32'h0);
    chk("reset vector",  32'(dvec),  32'h0);
    nc();
    reset_n = 1'b1;

    // Single level request on bit 3
    mask_we = 1'b1; mask_din = 8'hFF; nc();
    mask_we = 1'b0; req = 8'h08; nc();
    req = 8'h00;
    chk("t1 pending", 32'(dpend[7:0]), 32'h08);
    chk("t1 valid early", 32'(dv[0]), 32'h0);
    nc();
    chk("t1 valid", 32'(dv[0]), 32'h1);
    chk("t1 vector", 32'(dvec[2:0]), 32'd3);
    ack = 1'b1; nc();
    chk("t1 cleared", 32'(dpend[7:0]), 32'h00);
    chk("t1 idle", 32'(dv[0]), 32'h0);
    nc();
    ack = 1'b0;
    chk("t1 ack idle ignored", 32'(dv), 32'h0);

    // Two simultaneous requests, both priority directions
    req = 8'h90; nc();
    req = 8'h00; nc();
    chk("t2 first lo", 32'(dvec[2:0]), 32'd4);
    chk("t3 first hi", 32'(dvec[5:3]), 32'd7);
    ack = 1'b1; nc();
    ack = 1'b0;
    chk("t2 gap idle", 32'(dv[1:0]), 32'h0);
    chk("t2 remaining lo", 32'(dpend[7:0]), 32'h80);
    chk("t3 remaining hi", 32'(dpend[15:8]), 32'h10);
    nc();
    chk("t2 second lo", 32'(dvec[2:0]), 32'd7);
    chk("t3 second hi", 32'(dvec[5:3]), 32'd4);
    ack = 1'b1; nc();
    ack = 1'b0; nc();

    // No preemption while presenting
    req = 8'h20; nc();
    req = 8'h00; nc();
    chk("t4 vector 5", 32'(dvec[2:0]), 32'd5);
    req = 8'h01; nc();
    req = 8'h00; nc();
    chk("t4 held", 32'(dvec[2:0]), 32'd5);
    chk("t4 pending", 32'(dpend[7:0]), 32'h21);
    ack = 1'b1; nc();
    ack = 1'b0; nc();
    chk("t4 next vector", 32'(dvec[2:0]), 32'd0);
    chk("t4 next valid", 32'(dv[0]), 32'h1);
    ack = 1'b1; nc();
    ack = 1'b0; nc();

    // Mask hides but does not clear
    mask_we = 1'b1; mask_din = 8'hFE; nc();
    mask_we = 1'b0; req = 8'h01; nc(3);
    chk("t5 masked pending", 32'(dpend[7:0]), 32'h01);
    chk("t5 masked valid", 32'(dv), 32'h0);
    mask_we = 1'b1; mask_din = 8'hFF; nc();
    mask_we = 1'b0;
    chk("t5 unmask latency", 32'(dv[0]), 32'h0);
    nc();
    chk("t5 unmasked valid", 32'(dv[0]), 32'h1);
    chk("t5 unmasked vector", 32'(dvec[2:0]), 32'd0);
    ack = 1'b1; nc();
    ack = 1'b0;
    chk("t5 level re-pend", 32'(dpend[7:0]), 32'h01);
    chk("t5 edge no re-pend", 32'(dpend[23:16]), 32'h00);
    drain();

    // Edge bit held high presents exactly once
    req = 8'h01;
    for (int c = 0; c < 10; c++) begin
      ack = dv[2];
      if (dv[2]) pres++;
      nc();
    end
    ack = 1'b0;
    chk("t6 edge presentations", 32'(pres), 32'd1);
    drain();

    // New edge coinciding with ack keeps the bit pending
    req = 8'h01; nc();
    req = 8'h00; nc();
    chk("t6 edge valid", 32'(dv[2]), 32'h1);
    ack = 1'b1; req = 8'h01; nc();
    ack = 1'b0; req = 8'h00;
    chk("t6 set wins", 32'(dpend[23:16]), 32'h01);
    chk("t6 set wins idle", 32'(dv[2]), 32'h0);
    nc();
    chk("t6 re-presented", 32'(dv[2]), 32'h1);
    chk("t6 re-presented vec", 32'(dvec[8:6]), 32'd0);

    // Asynchronous reset mid-handshake
    #2;
    reset_n = 1'b0;
    req = 8'h01;
    #1;
    chk("t6 async valid", 32'(dv), 32'h0);
    chk("t6 async pending", 32'(dpend), 32'h0);
    nc(2);
    reset_n = 1'b1;
    nc();
    chk("t6 edge after reset", 32'(dpend[23:16]), 32'h01);
    chk("t6 level after reset", 32'(dpend[7:0]), 32'h01);
    req = 8'h00;
    nc(2);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
